// File: rtl/uart_fifo_core.sv
// Full-duplex 16x-oversampled UART with a shared baud-tick generator and
// one circular FIFO per direction behind a simple rd/wr host interface.
`timescale 1ns/1ps
module uart_fifo_core #(
  parameter int dbit  = 8,
  parameter int stick = 16,
  parameter int depth = 16,
  parameter int dvsr  = 651
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_in,
  input  logic            rd,
  input  logic            wr,
  input  logic [dbit-1:0] wr_data,
  output logic            empty,
  output logic            full,
  output logic [dbit-1:0] rd_data,
  output logic            tx_out
);

  localparam int CW = (dvsr > 1) ? $clog2(dvsr) : 1;
  localparam int SW = (stick > 16) ? $clog2(stick) : 4;
  localparam int NW = (dbit > 1) ? $clog2(dbit) : 1;
  localparam int AW = $clog2(depth);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} st_t;

  // Baud tick generator
  logic [CW-1:0] baud_cnt;
  logic          tick;

  assign tick = (baud_cnt == CW'(dvsr - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) baud_cnt <= '0;
    else      baud_cnt <= tick ? '0 : baud_cnt + CW'(1);
  end

  // rx_in synchroniser, reset to the idle-high line level
  logic rx_sync_p0, rx_sync_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
    end else begin
      rx_sync_p0 <= rx_in;
      rx_sync_p1 <= rx_sync_p0;
    end
  end

  // Receiver FSM
  st_t             rx_state, rx_state_nx;
  logic [SW-1:0]   rx_s, rx_s_nx;
  logic [NW-1:0]   rx_n, rx_n_nx;
  logic [dbit-1:0] rx_b, rx_b_nx;
  logic            rx_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= IDLE;
      rx_s     <= '0;
      rx_n     <= '0;
    end else begin
      rx_state <= rx_state_nx;
      rx_s     <= rx_s_nx;
      rx_n     <= rx_n_nx;
    end
  end

  always_ff @(posedge clk) begin
    rx_b <= rx_b_nx;
  end

  always_comb begin
    rx_state_nx = rx_state;
    rx_s_nx     = rx_s;
    rx_n_nx     = rx_n;
    rx_b_nx     = rx_b;
    rx_done     = 1'b0;
    case (rx_state)
      IDLE: begin
        if (!rx_sync_p1) begin
          rx_state_nx = START;
          rx_s_nx     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (rx_s == SW'(7)) begin
            rx_state_nx = DATA;
            rx_s_nx     = '0;
            rx_n_nx     = '0;
          end else begin
            rx_s_nx = rx_s + SW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (rx_s == SW'(15)) begin
            rx_s_nx = '0;
            rx_b_nx = {rx_sync_p1, rx_b[dbit-1:1]};
            if (rx_n == NW'(dbit - 1)) rx_state_nx = STOP;
            else                       rx_n_nx     = rx_n + NW'(1);
          end else begin
            rx_s_nx = rx_s + SW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (rx_s == SW'(stick - 1)) begin
            rx_done     = 1'b1;
            rx_state_nx = IDLE;
          end else begin
            rx_s_nx = rx_s + SW'(1);
          end
        end
      end
      default: rx_state_nx = IDLE;
    endcase
  end

  // RX FIFO: pointers carry one wrap bit so full and empty are distinguishable
  logic [dbit-1:0] rx_mem [depth];
  logic [PW-1:0]   rx_wptr, rx_rptr;
  logic            rx_empty, rx_full, rx_push, rx_pop;

  assign rx_empty = (rx_wptr == rx_rptr);
  assign rx_full  = (rx_wptr[AW] != rx_rptr[AW]) && (rx_wptr[AW-1:0] == rx_rptr[AW-1:0]);
  assign rx_push  = rx_done && !rx_full;
  assign rx_pop   = rd && !rx_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_wptr <= '0;
      rx_rptr <= '0;
      rd_data <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + PW'(1);
      if (rx_pop) begin
        rx_rptr <= rx_rptr + PW'(1);
        rd_data <= rx_mem[rx_rptr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr[AW-1:0]] <= rx_b;
  end

  assign empty = rx_empty;

  // TX FIFO
  logic [dbit-1:0] tx_mem [depth];
  logic [PW-1:0]   tx_wptr, tx_rptr;
  logic            tx_empty, tx_full, tx_push, tx_pop;

  assign tx_empty = (tx_wptr == tx_rptr);
  assign tx_full  = (tx_wptr[AW] != tx_rptr[AW]) && (tx_wptr[AW-1:0] == tx_rptr[AW-1:0]);
  assign tx_push  = wr && !tx_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + PW'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr[AW-1:0]] <= wr_data;
  end

  assign full = tx_full;

  // Transmitter FSM. A frame only starts on a tick so the start bit is a
  // full 16 ticks; the final stop tick chains straight into the next frame.
  st_t             tx_state, tx_state_nx;
  logic [SW-1:0]   tx_s, tx_s_nx;
  logic [NW-1:0]   tx_n, tx_n_nx;
  logic [dbit-1:0] tx_b, tx_b_nx;
  logic            tx_out_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= IDLE;
      tx_s     <= '0;
      tx_n     <= '0;
      tx_out   <= 1'b1;
    end else begin
      tx_state <= tx_state_nx;
      tx_s     <= tx_s_nx;
      tx_n     <= tx_n_nx;
      tx_out   <= tx_out_nx;
    end
  end

  always_ff @(posedge clk) begin
    tx_b <= tx_b_nx;
  end

  always_comb begin
    tx_state_nx = tx_state;
    tx_s_nx     = tx_s;
    tx_n_nx     = tx_n;
    tx_b_nx     = tx_b;
    tx_pop      = 1'b0;
    case (tx_state)
      IDLE: begin
        if (tick && !tx_empty) begin
          tx_b_nx     = tx_mem[tx_rptr[AW-1:0]];
          tx_pop      = 1'b1;
          tx_state_nx = START;
          tx_s_nx     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (tx_s == SW'(15)) begin
            tx_state_nx = DATA;
            tx_s_nx     = '0;
            tx_n_nx     = '0;
          end else begin
            tx_s_nx = tx_s + SW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tx_s == SW'(15)) begin
            tx_s_nx = '0;
            tx_b_nx = {1'b0, tx_b[dbit-1:1]};
            if (tx_n == NW'(dbit - 1)) tx_state_nx = STOP;
            else                       tx_n_nx     = tx_n + NW'(1);
          end else begin
            tx_s_nx = tx_s + SW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tx_s == SW'(stick - 1)) begin
            tx_s_nx = '0;
            if (!tx_empty) begin
              tx_b_nx     = tx_mem[tx_rptr[AW-1:0]];
              tx_pop      = 1'b1;
              tx_state_nx = START;
            end else begin
              tx_state_nx = IDLE;
            end
          end else begin
            tx_s_nx = tx_s + SW'(1);
          end
        end
      end
      default: tx_state_nx = IDLE;
    endcase

    case (tx_state_nx)
      START:   tx_out_nx = 1'b0;
      DATA:    tx_out_nx = tx_b_nx[0];
      default: tx_out_nx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_fifo_core.sv
// Randomized self-checking bench for uart_fifo_core: queue-based RX/TX
// reference model plus a free-running serial frame monitor on tx_out.
`timescale 1ns/1ps
module tb_uart_fifo_core;

  localparam int DBIT  = 8;
  localparam int STICK = 16;
  localparam int DEPTH = 16;
  localparam int DVSR  = 4;
  localparam int BIT   = 16 * DVSR;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic       rd = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       empty, full, tx_out;
  logic [7:0] rd_data;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] rx_q [$];
  logic [7:0] rd_last = 8'h00;
  logic [7:0] tx_q [$];
  int         tx_acc = 0;
  int         tx_started = 0;
  int         tx_done = 0;

  uart_fifo_core #(.dbit(DBIT), .stick(STICK), .depth(DEPTH), .dvsr(DVSR)) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_in   (rx_in),
    .rd      (rd),
    .wr      (wr),
    .wr_data (wr_data),
    .empty   (empty),
    .full    (full),
    .rd_data (rd_data),
    .tx_out  (tx_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic rx_send(input logic [7:0] b);
    logic pre;
    pre = (rx_q.size() == 0);
    @(negedge clk);
    rx_in = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    chk("empty_stop_begin", 32'(empty), 32'(pre));
    repeat (BIT - 2) @(negedge clk);
    if (rx_q.size() < DEPTH) rx_q.push_back(b);
    chk("empty_after_frame", 32'(empty), 32'(rx_q.size() == 0));
  endtask

  task automatic rx_rd();
    @(negedge clk);
    chk("empty_before_rd", 32'(empty), 32'(rx_q.size() == 0));
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    if (rx_q.size() != 0) rd_last = rx_q.pop_front();
    chk("rd_data", 32'(rd_data), 32'(rd_last));
  endtask

  task automatic tx_write(input logic [7:0] b);
    @(negedge clk);
    chk("full_before_wr", 32'(full), 32'((tx_acc - tx_started) == DEPTH));
    wr = 1'b1;
    wr_data = b;
    if ((tx_acc - tx_started) < DEPTH) begin
      tx_q.push_back(b);
      tx_acc++;
    end
  endtask

  task automatic wr_end();
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic tx_drain();
    int t;
    t = 0;
    while (tx_done != tx_acc && t < 20 * 10 * BIT) begin
      @(negedge clk);
      t++;
    end
    chk("tx_drain", 32'(tx_done), 32'(tx_acc));
  endtask

  // Serial monitor: samples the first and last cycle of every bit cell.
  initial begin : tx_mon
    logic       prev;
    logic       aborted;
    logic [9:0] f_first, f_last, exp_f;
    logic [7:0] eb;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst && prev && !tx_out) begin
        tx_started++;
        aborted = 1'b0;
        f_first = '0;
        f_last  = '0;
        for (int k = 0; k < 10; k++) begin
          for (int c = 0; c < BIT; c++) begin
            if (k != 0 || c != 0) @(negedge clk);
            if (!rst) aborted = 1'b1;
            if (c == 0)       f_first[k] = tx_out;
            if (c == BIT - 1) f_last[k]  = tx_out;
          end
        end
        chk("tx_frame_expected", 32'(tx_q.size() != 0), 32'd1);
        if (tx_q.size() != 0) begin
          eb = tx_q.pop_front();
          if (!aborted) begin
            exp_f = {1'b1, eb, 1'b0};
            chk("tx_bits_first", 32'(f_first), 32'(exp_f));
            chk("tx_bits_last", 32'(f_last), 32'(exp_f));
          end
        end
        tx_done++;
      end
      prev = tx_out;
    end
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0] pat;

    rst = 1'b0;
    rx_in = 1'b1;
    #100;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_tx_out", 32'(tx_out), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    chk("post_rst_empty", 32'(empty), 32'd1);
    chk("post_rst_full", 32'(full), 32'd0);
    chk("post_rst_rd_data", 32'(rd_data), 32'd0);
    chk("post_rst_tx_out", 32'(tx_out), 32'd1);

    rx_send(8'hA5);
    rx_rd();
    chk("empty_after_single", 32'(empty), 32'(rx_q.size() == 0));

    rx_send(8'h5A);
    chk("rd_hold_during_rx", 32'(rd_data), 32'(rd_last));
    rx_rd();
    repeat (20) @(negedge clk);
    chk("rd_hold_idle", 32'(rd_data), 32'(rd_last));

    tx_write(8'h3C);
    wr_end();
    chk("full_single_tx", 32'(full), 32'd0);
    tx_drain();

    // Fill the TX FIFO while the first frame is on the wire
    tx_write(8'h11);
    wr_end();
    repeat (2 * DVSR + 2) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) tx_write(8'($urandom_range(0, 255)));
    tx_write(8'hEE);
    wr_end();
    chk("full_held", 32'(full), 32'((tx_acc - tx_started) == DEPTH));
    tx_drain();
    chk("full_after_drain", 32'(full), 32'd0);

    for (int i = 0; i <= DEPTH; i++) rx_send(8'(i));
    for (int i = 0; i <= DEPTH; i++) rx_rd();

    for (int it = 0; it < 14; it++) begin
      case ($urandom_range(0, 2))
        0: if (rx_q.size() < DEPTH) rx_send(8'($urandom_range(0, 255)));
           else rx_rd();
        1: rx_rd();
        default: begin
          if ((tx_acc - tx_started) < 8) begin
            repeat ($urandom_range(1, 3)) tx_write(8'($urandom_range(0, 255)));
            wr_end();
          end
        end
      endcase
    end
    while (rx_q.size() != 0) rx_rd();
    tx_drain();

    // Reset in the middle of an RX frame and a TX frame
    rx_send(8'h7E);
    rx_rd();
    rx_send(8'h42);
    tx_write(8'h00);
    wr_end();
    pat = 8'hC3;
    @(negedge clk);
    rx_in = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx_in = pat[i];
      repeat (BIT) @(negedge clk);
    end
    rx_in = pat[3];
    repeat (BIT / 2) @(negedge clk);
    rst = 1'b0;
    #1;
    rx_q.delete();
    rd_last = 8'h00;
    chk("midrst_empty", 32'(empty), 32'(rx_q.size() == 0));
    chk("midrst_full", 32'(full), 32'd0);
    chk("midrst_rd_data", 32'(rd_data), 32'(rd_last));
    chk("midrst_tx_out", 32'(tx_out), 32'd1);
    rx_in = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    chk("after_midrst_empty", 32'(empty), 32'd1);
    rx_send(8'h81);
    rx_rd();
    chk("only_81_left", 32'(empty), 32'(rx_q.size() == 0));
    tx_drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
